// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game block and its keypad front end.
// Position codes are what the game block's 4-bit `in` port consumes.
package ttt_pkg;

    localparam int NUM_POS = 9;

    typedef logic [3:0] pos_t;

    localparam pos_t POS_NONE = 4'd0;
    localparam pos_t POS_1    = 4'd1;
    localparam pos_t POS_2    = 4'd2;
    localparam pos_t POS_3    = 4'd3;
    localparam pos_t POS_4    = 4'd4;
    localparam pos_t POS_5    = 4'd5;
    localparam pos_t POS_6    = 4'd6;
    localparam pos_t POS_7    = 4'd7;
    localparam pos_t POS_8    = 4'd8;
    localparam pos_t POS_9    = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ISSUE   = 2'd2,
        RELEASE = 2'd3
    } keypad_state_t;

    function automatic logic is_one_hot(input logic [NUM_POS-1:0] v);
        return (v != '0) && ((v & (v - 9'd1)) == '0);
    endfunction

    function automatic logic is_multi(input logic [NUM_POS-1:0] v);
        return (v != '0) && !is_one_hot(v);
    endfunction

    // Bit k of a one-hot button vector maps to board position k+1.
    function automatic pos_t encode_pos(input logic [NUM_POS-1:0] onehot);
        pos_t p;
        p = POS_NONE;
        for (int k = 0; k < NUM_POS; k++) begin
            if (onehot[k]) begin
                p = pos_t'(k + 1);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by async reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/move_keypad.sv
// Debounces nine board pushbuttons into a held position code with a one-cycle strobe
// per accepted press; multi-button presses and bounce never produce a code.
module move_keypad
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_POS-1:0] btn,
    output pos_t               move,
    output logic               move_valid,
    output logic               multi_press,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_POS-1:0] btn_s;
    logic [NUM_POS-1:0] cap, cap_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    keypad_state_t      state, state_next;
    pos_t               move_next;
    logic               move_valid_next;

    sync2 #(.WIDTH(NUM_POS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cap   <= cap_next;
        end
    end

    // The code and strobe are loaded on the edge that enters ISSUE, so both are
    // visible for exactly the ISSUE cycle and the code then holds.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        cap_next        = cap;
        move_next       = move;
        move_valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (is_one_hot(btn_s)) begin
                    cap_next   = btn_s;
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (btn_s != cap) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    move_next       = encode_pos(cap);
                    move_valid_next = 1'b1;
                    state_next      = ISSUE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = RELEASE;
            end
            RELEASE: begin
                // Any activity, including a re-press, restarts the quiet-time count.
                if (btn_s != '0) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move        <= POS_NONE;
            move_valid  <= 1'b0;
            multi_press <= 1'b0;
        end else begin
            move        <= move_next;
            move_valid  <= move_valid_next;
            multi_press <= is_multi(btn_s);
        end
    end

    assign busy = (state != IDLE);

    cap_one_hot_a: assert property (@(posedge clk) disable iff (rst)
        (state != IDLE) |-> $onehot(cap));

endmodule

// File: tb/tb_move_keypad.sv
// Bench for move_keypad: directed scenarios with literal expectations, then random
// button traffic, all checked every cycle against a run-length/timestamp model.
module tb_move_keypad;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] btn;
    logic [3:0] move;
    logic       move_valid;
    logic       multi_press;
    logic       busy;

    move_keypad #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .move        (move),
        .move_valid  (move_valid),
        .multi_press (multi_press),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  check_en = 1'b0;
    int  edge_n   = 0;
    int  strobe_cnt = 0;
    int  strobe_edge[$];
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit one_hot9(input logic [8:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [3:0] pos_of(input logic [8:0] v);
        for (int i = 0; i < 9; i++) begin
            if (v[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    // Model: btn_s is btn delayed by two sampling edges. Acquisition succeeds when a
    // one-hot value is unchanged for D edges after the first edge it is observed while
    // listening; release completes after D consecutive zero samples counted from two
    // edges after the issue edge.
    logic [8:0] m_s1, m_s2, m_v, m_run_val;
    int         m_run_start, m_listen, m_issue_edge, m_rel_zero, m_start;
    bit         m_rel, m_prev_active;
    logic [3:0] exp_move;
    bit         exp_valid, exp_multi, exp_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_run_val = '0;
            m_run_start = edge_n; m_listen = edge_n;
            m_rel = 1'b0; m_rel_zero = 0; m_issue_edge = 0;
            exp_move = 4'd0; exp_valid = 1'b0; exp_multi = 1'b0; exp_busy = 1'b0;
            exp_q.delete();
        end else begin
            edge_n++;
            m_v  = m_s2;
            m_s2 = m_s1;
            m_s1 = btn;
            m_prev_active = !m_rel && one_hot9(m_run_val) && (edge_n - 1 >= m_listen);
            if (m_v != m_run_val) begin
                if (m_prev_active) m_listen = edge_n + 1;
                m_run_val   = m_v;
                m_run_start = edge_n;
            end
            exp_valid = 1'b0;
            exp_multi = ($countones(m_v) >= 2);
            if (m_rel) begin
                if (edge_n >= m_issue_edge + 2) begin
                    m_rel_zero = (m_v == '0) ? m_rel_zero + 1 : 0;
                    if (m_rel_zero == D) begin
                        m_rel    = 1'b0;
                        m_listen = edge_n + 1;
                    end
                end
            end else if (edge_n >= m_listen && one_hot9(m_v)) begin
                m_start = (m_run_start > m_listen) ? m_run_start : m_listen;
                if (edge_n - m_start == D) begin
                    exp_valid    = 1'b1;
                    exp_move     = pos_of(m_v);
                    m_rel        = 1'b1;
                    m_issue_edge = edge_n;
                    m_rel_zero   = 0;
                    exp_q.push_back(exp_move);
                end
            end
            exp_busy = m_rel || (edge_n >= m_listen && one_hot9(m_v));
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("move", move, exp_move);
            check("move_valid", move_valid, exp_valid);
            check("multi_press", multi_press, exp_multi);
            check("busy", busy, exp_busy);
            if (move_valid === 1'b1) begin
                strobe_cnt++;
                strobe_edge.push_back(edge_n);
                if (exp_q.size() == 0) check("strobe_expected", 1, 0);
                else check("strobe_code", move, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a, b, kind;
        rst = 1'b1;
        btn = '0;
        step(3);
        check("rst_move", move, 0);
        check("rst_valid", move_valid, 0);
        check("rst_multi", multi_press, 0);
        check("rst_busy", busy, 0);
        check_en = 1'b1;
        rst = 1'b0;
        step(4);

        // Clean press of position 5
        s0 = strobe_cnt;
        btn = 9'h010;
        step(6); check("t1_valid_early", move_valid, 0);
        step(1); check("t1_valid", move_valid, 1); check("t1_move", move, 5);
        step(13); btn = '0;
        step(5); check("t1_busy_hold", busy, 1);
        step(1); check("t1_busy_idle", busy, 0); check("t1_move_held", move, 5);
        check("t1_strobes", strobe_cnt - s0, 1);

        // Bounce on position 1
        s0 = strobe_cnt;
        btn = 9'h001; step(1); btn = '0; step(1);
        btn = 9'h001; step(1); btn = '0; step(1);
        btn = 9'h001;
        step(6); check("t2_valid_early", move_valid, 0);
        step(1); check("t2_valid", move_valid, 1); check("t2_move", move, 1);
        step(5); btn = '0; step(8);
        check("t2_strobes", strobe_cnt - s0, 1);
        check("t2_busy", busy, 0);

        // Two buttons held, then one
        s0 = strobe_cnt;
        btn = 9'h003; step(30);
        check("t3_multi", multi_press, 1);
        check("t3_busy", busy, 0);
        check("t3_move", move, 1);
        check("t3_no_strobe", strobe_cnt - s0, 0);
        btn = 9'h002;
        step(7); check("t3_valid", move_valid, 1); check("t3_move2", move, 2);
        check("t3_multi_clear", multi_press, 0);
        btn = '0; step(8);
        check("t3_strobes", strobe_cnt - s0, 1);

        // Release glitch on position 9
        s0 = strobe_cnt;
        btn = 9'h100;
        step(7); check("t4_valid", move_valid, 1); check("t4_move", move, 9);
        btn = '0; step(3);
        btn = 9'h100; step(1);
        btn = '0;
        step(5); check("t4_busy_hold", busy, 1);
        step(1); check("t4_busy_idle", busy, 0);
        check("t4_strobes", strobe_cnt - s0, 1);
        check("t4_move_held", move, 9);

        // Reset in the second SETTLE cycle with position 7 held
        s0 = strobe_cnt;
        btn = 9'h040;
        step(4);
        rst = 1'b1;
        #1;
        check("t5_rst_move", move, 0);
        check("t5_rst_valid", move_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_multi", multi_press, 0);
        step(2);
        rst = 1'b0;
        step(6); check("t5_valid_early", move_valid, 0); check("t5_move_zero", move, 0);
        step(1); check("t5_valid", move_valid, 1); check("t5_move", move, 7);
        btn = '0; step(8);
        check("t5_busy", busy, 0);
        check("t5_strobes", strobe_cnt - s0, 1);

        // Position 3 twice
        s0 = strobe_cnt;
        btn = 9'h004;
        step(7); check("t6_valid1", move_valid, 1); check("t6_move1", move, 3);
        btn = '0; step(6);
        btn = 9'h004;
        step(7); check("t6_valid2", move_valid, 1); check("t6_move2", move, 3);
        btn = '0; step(8);
        check("t6_strobes", strobe_cnt - s0, 2);
        if (strobe_cnt - s0 >= 2) begin
            check("t6_spacing", (strobe_edge[strobe_edge.size()-1]
                                 - strobe_edge[strobe_edge.size()-2]) >= 2 * D + 3, 1);
        end

        // Random traffic
        for (int seg = 0; seg < 400; seg++) begin
            kind = $urandom_range(0, 19);
            if (kind < 4) begin
                btn = '0;
            end else if (kind < 13) begin
                btn = 9'd1 << $urandom_range(0, 8);
            end else if (kind < 16) begin
                a = $urandom_range(0, 8);
                b = (a + $urandom_range(1, 8)) % 9;
                btn = (9'd1 << a) | (9'd1 << b);
            end else if (kind < 19) begin
                btn = 9'($urandom);
            end else begin
                rst = 1'b1;
                step($urandom_range(1, 2));
                rst = 1'b0;
            end
            step($urandom_range(1, 12));
        end

        btn = '0;
        step(12);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
